breg_rtype_sequencer: RTL and testbench

// - Initiator that drives the register bank port (RA1/RA2 read, AW/Di/RegWrite write).
// - Accepts one 32-bit R-type instruction per valid/ready handshake, then:
//   - reads rs and rt from the bank;
//   - executes the funct operation;
//   - writes the result back to rd.
// - Sits between the instruction source and the register bank of the datapath.

---
 rtl/breg_pkg.sv | 44 ++++
 rtl/breg_alu.sv | 51 +++++
 rtl/breg_rtype_sequencer.sv | 152 +++++++++++++++
 tb/tb_breg_rtype_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/breg_pkg.sv
// Shared definitions for the R-type register-bank sequencer: opcode/funct
// codes, FSM state encoding and instruction field extraction helpers.
package breg_pkg;

    localparam int DW_DEFAULT   = 32;
    localparam int AWID_DEFAULT = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    function automatic logic [5:0] f_op(input logic [31:0] w);
        return w[31:26];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] w);
        return w[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] w);
        return w[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] w);
        return w[15:11];
    endfunction

    function automatic logic [5:0] f_funct(input logic [31:0] w);
        return w[5:0];
    endfunction

endpackage

// File: rtl/breg_alu.sv
// Combinational R-type ALU. Arithmetic wraps modulo 2^DW; any funct outside
// the supported set reports legal=0 with a zero result.
module breg_alu
    import breg_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [5:0]    funct,
    output logic [DW-1:0] y,
    output logic          legal
);

    // Decode funct and compute the operation result.
    always_comb begin
        y     = {DW{1'b0}};
        legal = 1'b0;
        case (funct)
            F_ADD: begin
                y     = a + b;
                legal = 1'b1;
            end
            F_SUB: begin
                y     = a - b;
                legal = 1'b1;
            end
            F_AND: begin
                y     = a & b;
                legal = 1'b1;
            end
            F_OR: begin
                y     = a | b;
                legal = 1'b1;
            end
            F_NOR: begin
                y     = ~(a | b);
                legal = 1'b1;
            end
            F_SLT: begin
                y     = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
                legal = 1'b1;
            end
            default: begin
                y     = {DW{1'b0}};
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/breg_rtype_sequencer.sv
// Sequencer that takes one R-type instruction per handshake, reads rs/rt from
// the register bank, executes funct and writes the result back to rd.
// IDLE -> READ -> EXEC -> WB, one cycle each; all outputs are registered.
module breg_rtype_sequencer
    import breg_pkg::*;
#(
    parameter int DW   = 32,
    parameter int AWID = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic [AWID-1:0] RA1,
    output logic [AWID-1:0] RA2,
    input  logic [DW-1:0]   DR1,
    input  logic [DW-1:0]   DR2,
    output logic [AWID-1:0] AW,
    output logic [DW-1:0]   Di,
    output logic            RegWrite,
    output logic            done,
    output logic            err,
    output logic [DW-1:0]   result
);

    state_t          state_r;
    state_t          state_next_s;
    logic [31:0]     instr_r;
    logic [DW-1:0]   opa_r;
    logic [DW-1:0]   opb_r;
    logic [DW-1:0]   result_r;
    logic [AWID-1:0] ra1_r;
    logic [AWID-1:0] ra2_r;
    logic [AWID-1:0] aw_r;
    logic            in_ready_r;
    logic            regwrite_r;
    logic            done_r;
    logic            err_r;

    logic            accept_s;
    logic [DW-1:0]   alu_y_s;
    logic            alu_legal_s;
    logic            legal_s;
    logic            rd_nonzero_s;
    logic            shamt_unused_s;

    assign accept_s       = (state_r == IDLE) && in_valid && in_ready_r;
    assign legal_s        = alu_legal_s && (f_op(instr_r) == OP_RTYPE);
    assign rd_nonzero_s   = (f_rd(instr_r) != 5'd0);
    // The shamt field has no meaning for the supported operations.
    assign shamt_unused_s = ^instr_r[10:6];

    breg_alu #(
        .DW (DW)
    ) u_alu (
        .a     (opa_r),
        .b     (opb_r),
        .funct (f_funct(instr_r)),
        .y     (alu_y_s),
        .legal (alu_legal_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: wait for a handshake, then walk the fixed pipeline.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = READ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            READ:    state_next_s = EXEC;
            EXEC:    state_next_s = WB;
            WB:      state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Instruction/operand capture, execution and registered port drive.
    // Strobes are loaded on the edge entering WB so they are high in WB only.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_r    <= 32'd0;
            opa_r      <= {DW{1'b0}};
            opb_r      <= {DW{1'b0}};
            result_r   <= {DW{1'b0}};
            ra1_r      <= {AWID{1'b0}};
            ra2_r      <= {AWID{1'b0}};
            aw_r       <= {AWID{1'b0}};
            in_ready_r <= 1'b1;
            regwrite_r <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            in_ready_r <= (state_next_s == IDLE);
            regwrite_r <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        instr_r <= instr;
                        ra1_r   <= AWID'(f_rs(instr));
                        ra2_r   <= AWID'(f_rt(instr));
                    end
                end
                READ: begin
                    opa_r <= DR1;
                    opb_r <= DR2;
                end
                EXEC: begin
                    if (legal_s) begin
                        result_r <= alu_y_s;
                    end
                    aw_r       <= AWID'(f_rd(instr_r));
                    done_r     <= 1'b1;
                    err_r      <= ~legal_s;
                    regwrite_r <= legal_s && rd_nonzero_s;
                end
                WB: begin
                    done_r <= 1'b0;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_r;
    assign RA1      = ra1_r;
    assign RA2      = ra2_r;
    assign AW       = aw_r;
    assign Di       = result_r;
    assign result   = result_r;
    assign RegWrite = regwrite_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_breg_rtype_sequencer.sv
// Directed bench for breg_rtype_sequencer with a behavioural register bank.
module tb_breg_rtype_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [4:0]  RA1;
    logic [4:0]  RA2;
    logic [31:0] DR1;
    logic [31:0] DR2;
    logic [4:0]  AW;
    logic [31:0] Di;
    logic        RegWrite;
    logic        done;
    logic        err;
    logic [31:0] result;

    int vectors     = 0;
    int miscompares = 0;

    logic        preload;
    logic [31:0] bank [32];
    int          cyc       = 0;
    int          hs_cnt    = 0;
    int          done_cnt  = 0;
    int          wr_cnt    = 0;
    int          rw_double = 0;
    logic        rw_prev   = 1'b0;
    int          hs_cyc  [32];
    logic [4:0]  wr_addr [32];
    logic [31:0] wr_data [32];

    breg_rtype_sequencer #(.DW(32), .AWID(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .RA1      (RA1),
        .RA2      (RA2),
        .DR1      (DR1),
        .DR2      (DR2),
        .AW       (AW),
        .Di       (Di),
        .RegWrite (RegWrite),
        .done     (done),
        .err      (err),
        .result   (result)
    );

    always #5 clk = ~clk;

    assign DR1 = bank[RA1];
    assign DR2 = bank[RA2];

    // Bank model and event monitor: writes, handshakes, done pulses.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (preload) begin
            for (int i = 0; i < 32; i++) bank[i] <= 32'd0;
            bank[1] <= 32'd5;
            bank[2] <= 32'd7;
            bank[6] <= 32'hFFFF_FFFF;
            bank[7] <= 32'd1;
        end else if (RegWrite && AW != 5'd0) begin
            bank[AW] <= Di;
        end
        if (!rst && in_valid && in_ready) begin
            if (hs_cnt < 32) hs_cyc[hs_cnt] <= cyc;
            hs_cnt <= hs_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (RegWrite && rw_prev) rw_double <= rw_double + 1;
        rw_prev <= RegWrite;
        if (RegWrite) begin
            if (wr_cnt < 32) begin
                wr_addr[wr_cnt] <= AW;
                wr_data[wr_cnt] <= Di;
            end
            wr_cnt <= wr_cnt + 1;
        end
    end

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [5:0] fn);
        return {op, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction, checking every state cycle.
    task automatic run_instr(input string tag, input logic [31:0] w, input logic exp_err,
                             input logic exp_we, input logic [4:0] exp_aw,
                             input logic [31:0] exp_di);
        @(negedge clk);
        chk({tag, ".ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        instr    = w;
        @(negedge clk);
        in_valid = 1'b0;
        instr    = 32'hDEAD_BEEF;
        chk({tag, ".ra1"}, 32'(RA1), 32'(w[25:21]));
        chk({tag, ".ra2"}, 32'(RA2), 32'(w[20:16]));
        chk({tag, ".busy"}, 32'(in_ready), 32'd0);
        chk({tag, ".done_rd"}, 32'(done), 32'd0);
        @(negedge clk);
        chk({tag, ".done_ex"}, 32'(done), 32'd0);
        chk({tag, ".we_ex"}, 32'(RegWrite), 32'd0);
        @(negedge clk);
        chk({tag, ".done_wb"}, 32'(done), 32'd1);
        chk({tag, ".err"}, 32'(err), 32'(exp_err));
        chk({tag, ".we"}, 32'(RegWrite), 32'(exp_we));
        chk({tag, ".aw"}, 32'(AW), 32'(exp_aw));
        chk({tag, ".di"}, Di, exp_di);
        chk({tag, ".result"}, result, exp_di);
        @(negedge clk);
        chk({tag, ".done_off"}, 32'(done), 32'd0);
        chk({tag, ".we_off"}, 32'(RegWrite), 32'd0);
        chk({tag, ".ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int hs0;
        int w0;
        int dc0;

        rst      = 1'b1;
        preload  = 1'b1;
        in_valid = 1'b0;
        instr    = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst.ready", 32'(in_ready), 32'd1);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.we", 32'(RegWrite), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.ra1", 32'(RA1), 32'd0);
        chk("rst.ra2", 32'(RA2), 32'd0);
        chk("rst.aw", 32'(AW), 32'd0);
        chk("rst.di", Di, 32'd0);
        chk("rst.result", result, 32'd0);
        rst     = 1'b0;
        preload = 1'b0;

        run_instr("add",   enc(6'h00, 5'd1, 5'd2, 5'd3,  6'h20), 1'b0, 1'b1, 5'd3,  32'd12);
        run_instr("sub",   enc(6'h00, 5'd1, 5'd2, 5'd4,  6'h22), 1'b0, 1'b1, 5'd4,  32'hFFFF_FFFE);
        run_instr("slt",   enc(6'h00, 5'd1, 5'd2, 5'd5,  6'h2A), 1'b0, 1'b1, 5'd5,  32'd1);
        run_instr("slts1", enc(6'h00, 5'd6, 5'd7, 5'd8,  6'h2A), 1'b0, 1'b1, 5'd8,  32'd1);
        run_instr("slts0", enc(6'h00, 5'd7, 5'd6, 5'd9,  6'h2A), 1'b0, 1'b1, 5'd9,  32'd0);
        run_instr("and",   enc(6'h00, 5'd1, 5'd2, 5'd10, 6'h24), 1'b0, 1'b1, 5'd10, 32'd5);
        run_instr("or",    enc(6'h00, 5'd1, 5'd2, 5'd11, 6'h25), 1'b0, 1'b1, 5'd11, 32'd7);
        run_instr("nor",   enc(6'h00, 5'd1, 5'd2, 5'd12, 6'h27), 1'b0, 1'b1, 5'd12, 32'hFFFF_FFF8);
        run_instr("rd0",   enc(6'h00, 5'd1, 5'd2, 5'd0,  6'h20), 1'b0, 1'b0, 5'd0,  32'd12);
        chk("wrcount8", 32'(wr_cnt), 32'd8);
        chk("r0", bank[0], 32'd0);
        run_instr("badfn", enc(6'h00, 5'd1, 5'd2, 5'd13, 6'h3F), 1'b1, 1'b0, 5'd13, 32'd12);
        run_instr("badop", enc(6'h23, 5'd1, 5'd2, 5'd14, 6'h20), 1'b1, 1'b0, 5'd14, 32'd12);
        run_instr("alias", enc(6'h00, 5'd3, 5'd3, 5'd3,  6'h20), 1'b0, 1'b1, 5'd3,  32'd24);
        chk("wrcount9", 32'(wr_cnt), 32'd9);
        chk("alias.bank", bank[3], 32'd24);

        // in_valid low: an instruction on the bus must not be taken.
        hs0      = hs_cnt;
        dc0      = done_cnt;
        instr    = enc(6'h00, 5'd1, 5'd2, 5'd19, 6'h20);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("novalid.hs", 32'(hs_cnt), 32'(hs0));
        chk("novalid.done", 32'(done_cnt), 32'(dc0));

        // Three back-to-back instructions with in_valid held high.
        hs0 = hs_cnt;
        w0  = wr_cnt;
        @(negedge clk);
        in_valid = 1'b1;
        instr    = enc(6'h00, 5'd1, 5'd2, 5'd15, 6'h20);
        for (int t = 0; t < 40 && hs_cnt < hs0 + 3; t++) begin
            @(negedge clk);
            if (hs_cnt == hs0 + 1) instr = enc(6'h00, 5'd2, 5'd1, 5'd16, 6'h22);
            else if (hs_cnt == hs0 + 2) instr = enc(6'h00, 5'd15, 5'd16, 5'd17, 6'h25);
        end
        in_valid = 1'b0;
        chk("b2b.hs", 32'(hs_cnt - hs0), 32'd3);
        chk("b2b.gap1", 32'(hs_cyc[hs0 + 1] - hs_cyc[hs0]), 32'd4);
        chk("b2b.gap2", 32'(hs_cyc[hs0 + 2] - hs_cyc[hs0 + 1]), 32'd4);
        for (int t = 0; t < 20 && wr_cnt < w0 + 3; t++) @(negedge clk);
        chk("b2b.wr", 32'(wr_cnt - w0), 32'd3);
        chk("b2b.a0", 32'(wr_addr[w0]), 32'd15);
        chk("b2b.d0", wr_data[w0], 32'd12);
        chk("b2b.a1", 32'(wr_addr[w0 + 1]), 32'd16);
        chk("b2b.d1", wr_data[w0 + 1], 32'd2);
        chk("b2b.a2", 32'(wr_addr[w0 + 2]), 32'd17);
        chk("b2b.d2", wr_data[w0 + 2], 32'd14);

        // Reset asserted during EXEC aborts the instruction cleanly.
        repeat (2) @(negedge clk);
        dc0 = done_cnt;
        w0  = wr_cnt;
        in_valid = 1'b1;
        instr    = enc(6'h00, 5'd1, 5'd2, 5'd18, 6'h20);
        @(negedge clk);
        in_valid = 1'b0;
        chk("abort.busy", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.we", 32'(RegWrite), 32'd0);
        chk("abort.ready", 32'(in_ready), 32'd1);
        chk("abort.result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort.ready2", 32'(in_ready), 32'd1);
        repeat (4) @(negedge clk);
        chk("abort.donecnt", 32'(done_cnt), 32'(dc0));
        chk("abort.wrcnt", 32'(wr_cnt), 32'(w0));
        chk("abort.r18", bank[18], 32'd0);

        run_instr("after", enc(6'h00, 5'd1, 5'd2, 5'd18, 6'h20), 1'b0, 1'b1, 5'd18, 32'd12);
        chk("we.single", 32'(rw_double), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
